imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter ADDR_W, default 16, byte-address width of the external instruction ROM.
REQ-002 Parameter TIMEOUT, default 15, maximum cycles waited for each mem_ack before aborting.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 pc  input  DATA_WIDTH (32)  byte address of the instruction the fetch stage wants this cycle.
REQ-006 idata  output  32  instruction word returned to the fetch stage.
REQ-007 stall  output  1  high while idata is not valid for the current pc.
REQ-008 err  output  1  sticky flag for an out-of-range pc, a misaligned pc or a timeout.
REQ-009 mem_addr  output  ADDR_W  byte address driven to the external byte-wide ROM.
REQ-010 mem_rd  output  1  read request to the ROM.
REQ-011 mem_rdata  input  8  ROM read data, valid only when mem_ack is high.
REQ-012 mem_ack  input  1  ROM read-data-valid strobe, one byte per pulse.

Function
REQ-013 Each word is held in a one-entry line buffer with: 32-bit data, tag = word address pc[ADDR_W-1:2], and a valid bit.
REQ-014 FSM states: IDLE, READ, FILL.
REQ-015 IDLE hit (valid set and tag equals pc[ADDR_W-1:2]): idata = buffer data and stall = 0, both combinationally in the same cycle.
REQ-016 IDLE miss: stall = 1 combinationally in the same cycle.
  - On the next edge: go to READ, byte_cnt = 0, mem_addr = {pc[ADDR_W-1:2], 2'b00}, mem_rd = 1.
  - The miss word address is latched when READ is entered.
REQ-017 In READ, each mem_ack edge:
  - stores mem_rdata into buffer byte lane byte_cnt, little-endian (byte 0 -> bits 7:0);
  - increments byte_cnt and mem_addr;
  - resets the timeout counter.
REQ-018 After the 4th mem_ack, go to FILL with mem_rd = 0.
REQ-019 FILL: tag = latched word address, valid = 1, next state IDLE.
  - Miss-to-hit latency = 4 acks + 2 cycles.
  - stall stays high through READ and FILL.
REQ-020 mem_ack in IDLE or FILL is ignored.
REQ-021 pc changing during READ or FILL does not abort the fill.
  - The IDLE compare after FILL decides hit or miss for the new pc.
REQ-022 pc[1:0] != 0: treated as pc with bits [1:0] cleared; err set.
REQ-023 pc[31:ADDR_W] != 0: no ROM access, idata = 32'h00000000, stall = 0, err set; line buffer unchanged.
REQ-024 Timeout counter counts cycles in READ without mem_ack.
  - On reaching TIMEOUT: buffer data = 32'h00000000, tag = latched word address, valid = 1, mem_rd = 0, err set, state IDLE.
REQ-025 err is cleared only by reset.
REQ-026 When stall = 1, idata is don't-care but deterministic: it equals the buffer data.

Reset
REQ-027 reset low asynchronously forces:
  - state IDLE, valid = 0, tag = 0, buffer data = 0;
  - byte_cnt = 0, timeout counter = 0;
  - mem_rd = 0, mem_addr = 0, err = 0.
REQ-028 Reset asserted mid-READ abandons the fill; bytes already received are discarded.
  - The first post-reset cycle with a valid pc is a miss.
REQ-029 After reset release, no ROM request is issued before the first IDLE miss.

Structure
REQ-030 DATA_WIDTH and the IDLE/READ/FILL state encodings live in the shared package; ADDR_W and TIMEOUT are module parameters.
REQ-031 Single module; no sub-module. The line buffer and FSM are inline.

Verification
REQ-032 Reset, then pc = 0x0, ROM bytes 0x11/0x22/0x33/0x44 with ack every cycle -> mem_addr 0,1,2,3; stall high 6 cycles; then idata = 0x44332211 with stall = 0.
REQ-033 After REQ-032, pc held at 0x0 and then 0x2 -> both hits: stall = 0, no mem_rd, err = 1 after the 0x2 cycle.
REQ-034 pc = 0x4 with ack delayed 3 cycles per byte -> stall high 4*4+2 cycles; mem_addr steps 4..7.
REQ-035 pc = 0x00010000 (ADDR_W = 16) -> same-cycle idata = 0, stall = 0, err = 1, mem_rd stays 0.
REQ-036 pc = 0x8, ROM never acks -> after 15 cycles in READ: mem_rd drops; next IDLE cycle gives idata = 0, stall = 0, err = 1.
REQ-037 Reset pulsed after the 2nd ack of a fill -> mem_rd = 0 immediately; the same pc re-requests from byte 0 after release.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg: shared width and FSM encodings for the instruction-fetch responder.
package imem_responder_pkg;
   localparam int DATA_WIDTH = 32;
   typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, FILL = 2'd2} state_t;
endpackage

// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch-stage port plus byte-wide ROM port of the responder.
interface imem_responder_if
   import imem_responder_pkg::*;
#(parameter int ADDR_W = 16);
   logic [DATA_WIDTH-1:0] pc;
   logic [31:0] idata;
   logic stall;
   logic err;
   logic [ADDR_W-1:0] mem_addr;
   logic mem_rd;
   logic [7:0] mem_rdata;
   logic mem_ack;
   modport master (output pc, mem_rdata, mem_ack, input idata, stall, err, mem_addr, mem_rd);
   modport slave (input pc, mem_rdata, mem_ack, output idata, stall, err, mem_addr, mem_rd);
endinterface

// File: rtl/imem_responder.sv
// imem_responder: one-word line buffer filling 32-bit instructions from a byte-wide ROM.
module imem_responder
   import imem_responder_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int TIMEOUT = 15
) (
   input logic clock,
   input logic reset,
   imem_responder_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int WW = ADDR_W - 2;
   state_t state, state_nx;
   logic [31:0] line_data;
   logic [WW-1:0] line_tag, miss_wa;
   logic line_valid;
   logic [1:0] byte_cnt;
   logic [TW-1:0] tmo_cnt;
   logic oor, hit, miss, last_byte, expired;
   assign oor = |bus.pc[DATA_WIDTH-1:ADDR_W];
   assign hit = line_valid && line_tag == bus.pc[ADDR_W-1:2];
   assign miss = state == IDLE && !oor && !hit;
   assign last_byte = bus.mem_ack && byte_cnt == 2'd3;
   assign expired = !bus.mem_ack && tmo_cnt == TW'(TIMEOUT - 1);
   always_ff @(posedge clock or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state == IDLE ? (miss ? READ : IDLE)
               : state == READ ? (last_byte ? FILL : expired ? IDLE : READ)
               : IDLE;
   end
   // out-of-range pc is answered with zero without touching the line buffer
   always_comb begin
      bus.idata = state == IDLE && oor ? 32'h0 : line_data;
      bus.stall = !(state == IDLE && (oor || hit));
      bus.mem_rd = state == READ;
   end
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         line_data <= '0;
         line_tag <= '0;
         line_valid <= 1'b0;
         miss_wa <= '0;
         byte_cnt <= '0;
         tmo_cnt <= '0;
         bus.mem_addr <= '0;
         bus.err <= 1'b0;
      end else begin
         if (state == IDLE && (oor || |bus.pc[1:0])) bus.err <= 1'b1;
         if (miss) begin
            miss_wa <= bus.pc[ADDR_W-1:2];
            bus.mem_addr <= {bus.pc[ADDR_W-1:2], 2'b00};
            byte_cnt <= '0;
            tmo_cnt <= '0;
         end
         if (state == READ) begin
            if (bus.mem_ack) begin
               line_data[{byte_cnt, 3'b000} +: 8] <= bus.mem_rdata;
               byte_cnt <= byte_cnt + 2'd1;
               bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
               tmo_cnt <= '0;
            end else if (expired) begin
               line_data <= '0;
               line_tag <= miss_wa;
               line_valid <= 1'b1;
               bus.err <= 1'b1;
               tmo_cnt <= '0;
            end else tmo_cnt <= tmo_cnt + TW'(1);
         end
         if (state == FILL) begin
            line_tag <= miss_wa;
            line_valid <= 1'b1;
         end
      end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed fetch sequence against a byte-wide ROM model with an idata scoreboard.
module tb_imem_responder;
   import imem_responder_pkg::*;
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;
   imem_responder_if #(.ADDR_W(16)) bus ();
   imem_responder #(.ADDR_W(16), .TIMEOUT(15)) dut (.clock(clock), .reset(reset), .bus(bus));
   logic [7:0] rom [0:255];
   logic [15:0] acked [$];
   logic [31:0] exp_q [$];
   int ack_delay = 0, wait_cnt = 0, rd_cycles = 0, passed = 0, fails = 0, total = 0;
   bit rom_on = 1'b1;
   // ROM model: answers each byte request after ack_delay idle cycles
   always @(negedge clock) begin
      if (bus.mem_rd === 1'b1) rd_cycles++;
      if (bus.mem_rd === 1'b1 && rom_on && wait_cnt == ack_delay) begin
         bus.mem_ack = 1'b1;
         bus.mem_rdata = rom[bus.mem_addr[7:0]];
         acked.push_back(bus.mem_addr);
         wait_cnt = 0;
      end else begin
         bus.mem_ack = 1'b0;
         bus.mem_rdata = 8'hA5;
         wait_cnt = bus.mem_rd === 1'b1 ? wait_cnt + 1 : 0;
      end
   end
   function automatic logic [31:0] word(logic [31:0] a);
      logic [7:0] b = a[7:0];
      return {rom[b + 8'd3], rom[b + 8'd2], rom[b + 8'd1], rom[b]};
   endfunction
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask
   task automatic fetch(string tag, logic [31:0] a, logic [31:0] exp_data, int exp_stall);
      int n = 0;
      bus.pc = a;
      exp_q.push_back(exp_data);
      #1;
      while (bus.stall !== 1'b0 && n < 100) begin
         n++;
         @(negedge clock);
         #1;
      end
      chk({tag, "_stall_cycles"}, n, exp_stall);
      chk({tag, "_idata"}, bus.idata, exp_q.pop_front());
   endtask
   task automatic chk_addrs(string tag, logic [15:0] base);
      chk({tag, "_ack_count"}, acked.size(), 4);
      for (int i = 0; i < 4; i++)
         chk({tag, "_mem_addr"}, i < acked.size() ? acked[i] : 16'hxxxx, base + 16'(i));
      acked.delete();
   endtask
   task automatic pulse_reset();
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int n;
      for (int i = 0; i < 256; i++) rom[i] = 8'((i + 1) * 17);
      bus.pc = 32'h0;
      repeat (2) @(negedge clock);
      #1;
      chk("rst_mem_rd", bus.mem_rd, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_stall", bus.stall, 1);
      chk("rst_idata", bus.idata, 0);
      acked.delete();
      rd_cycles = 0;
      @(negedge clock);
      reset = 1'b1;
      fetch("r032", 32'h0, 32'h44332211, 6);
      chk_addrs("r032", 16'h0);
      chk("r032_rd_cycles", rd_cycles, 4);
      @(negedge clock);
      #1;
      chk("r033_hold_stall", bus.stall, 0);
      chk("r033_hold_rd", bus.mem_rd, 0);
      @(negedge clock);
      fetch("r033_pc2", 32'h2, 32'h44332211, 0);
      chk("r033_err_pre", bus.err, 0);
      @(negedge clock);
      bus.pc = 32'h0;
      #1;
      chk("r033_err", bus.err, 1);
      chk("r033_rd", bus.mem_rd, 0);
      chk("r033_stall", bus.stall, 0);
      ack_delay = 3;
      @(negedge clock);
      fetch("r034", 32'h4, word(32'h4), 18);
      chk_addrs("r034", 16'h4);
      ack_delay = 0;
      pulse_reset();
      fetch("r035_fill", 32'h0, word(32'h0), 6);
      acked.delete();
      @(negedge clock);
      #1;
      chk("r035_err_pre", bus.err, 0);
      @(negedge clock);
      fetch("r035_oor", 32'h00010000, 32'h0, 0);
      chk("r035_rd_same", bus.mem_rd, 0);
      @(negedge clock);
      #1;
      chk("r035_err", bus.err, 1);
      chk("r035_rd", bus.mem_rd, 0);
      @(negedge clock);
      fetch("r035_keep", 32'h0, word(32'h0), 0);
      rom_on = 1'b0;
      pulse_reset();
      rd_cycles = 0;
      fetch("r036", 32'h8, 32'h0, 16);
      chk("r036_rd_cycles", rd_cycles, 15);
      chk("r036_err", bus.err, 1);
      chk("r036_rd", bus.mem_rd, 0);
      rom_on = 1'b1;
      pulse_reset();
      acked.delete();
      bus.pc = 32'hC;
      n = 0;
      while (acked.size() < 2 && n < 20) begin
         n++;
         @(negedge clock);
         #1;
      end
      chk("r037_two_acks", acked.size(), 2);
      @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      chk("r037_rd_reset", bus.mem_rd, 0);
      chk("r037_addr_reset", bus.mem_addr, 0);
      chk("r037_stall_reset", bus.stall, 1);
      acked.delete();
      @(negedge clock);
      reset = 1'b1;
      fetch("r037", 32'hC, word(32'hC), 6);
      chk_addrs("r037", 16'hC);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
